// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
// Multi-cycle control sequencer for the RISC core. Each instruction walks
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The sequencer drives the memory
// handshakes, register-file write enable, PC update and retire counter.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   run                 allow fetching of new instructions
//   imem_ready          instruction word valid this cycle
//   dmem_ready          data access complete this cycle
//   dec_*               per-instruction control bits from the decoder
//   br_taken            branch condition, valid in EXEC
//   imem_req, ir_load   instruction fetch request / IR load strobe
//   dmem_req, dmem_we   data memory request / write
//   rf_we               register file write enable
//   pc_we, pc_src       PC update strobe (marks retire) and PC source select
//   state, busy, err    current state, in-flight flag, sticky timeout error
//   instr_count         retired instruction count (wraps)
module multicycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             dec_reg_write,
  input  logic             dec_data_read,
  input  logic             dec_data_write,
  input  logic [1:0]       dec_pc_sel,
  input  logic             dec_branch,
  input  logic             br_taken,
  output logic             imem_req,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic [2:0]       state,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StErr    = 3'd6
  } state_e;

  // The wait counter only ever needs to reach MEM_TIMEOUT-1.
  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
      (MEM_TIMEOUT == 0) ? '0 : WAIT_W'(MEM_TIMEOUT - 1);

  state_e             r_state;
  state_e             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WAIT_W-1:0]  r_wait;
  logic               r_br_taken;
  logic               w_wait_last;
  logic               w_taken;
  logic               w_stall;

  // This request cycle is the last one allowed without ready.
  assign w_wait_last = (MEM_TIMEOUT != 0) && (r_wait == WAIT_LAST);

  // Branches retire in EXEC, so use the live condition there.
  assign w_taken = (r_state == StExec) ? br_taken : r_br_taken;

  assign w_stall = ((r_state == StFetch) && !imem_ready) ||
                   ((r_state == StMem) && !dmem_ready);

  always_comb begin
    w_next   = r_state;
    imem_req = 1'b0;
    ir_load  = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    case (r_state)
      StIdle: begin
        if (run) w_next = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load = 1'b1;
          w_next  = StDecode;
        end else if (w_wait_last) begin
          w_next = StErr;
        end
      end
      StDecode: w_next = StExec;
      StExec: begin
        if (dec_data_read || dec_data_write) w_next = StMem;
        else if (dec_reg_write)              w_next = StWb;
        else                                 pc_we  = 1'b1;
      end
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = dec_data_write;
        if (dmem_ready) begin
          // A store retires here even if the load flag is also set.
          if (dec_data_write) pc_we  = 1'b1;
          else                w_next = StWb;
        end else if (w_wait_last) begin
          w_next = StErr;
        end
      end
      StWb: begin
        rf_we = 1'b1;
        pc_we = 1'b1;
      end
      StErr:   w_next = StErr;
      default: w_next = StIdle;
    endcase
    if (pc_we) w_next = run ? StFetch : StIdle;
  end

  always_comb begin
    pc_src = 2'b00;
    if (dec_pc_sel != 2'b00)         pc_src = dec_pc_sel;
    else if (dec_branch && w_taken)  pc_src = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_wait     <= '0;
      r_br_taken <= 1'b0;
    end else begin
      r_state <= w_next;
      if (pc_we) r_cnt <= r_cnt + CNT_W'(1);
      if (r_state == StExec) r_br_taken <= br_taken;
      // Anything outside a waiting request cycle clears the counter, so it
      // starts at zero on every entry to FETCH or MEM.
      if (w_stall) r_wait <= r_wait + WAIT_W'(1);
      else         r_wait <= '0;
    end
  end

  assign state       = r_state;
  assign busy        = (r_state != StIdle) && (r_state != StErr);
  assign err         = (r_state == StErr);
  assign instr_count = r_cnt;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer (MEM_TIMEOUT=15, CNT_W=4).
// Each driven instruction pushes its expected retire record; a monitor pops
// and compares it whenever pc_we is seen.
module tb_multicycle_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       dec_reg_write = 1'b0;
  logic       dec_data_read = 1'b0;
  logic       dec_data_write = 1'b0;
  logic [1:0] dec_pc_sel = 2'b00;
  logic       dec_branch = 1'b0;
  logic       br_taken = 1'b0;
  logic       imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_we;
  logic [1:0] pc_src;
  logic [2:0] state;
  logic       busy, err;
  logic [3:0] instr_count;

  multicycle_sequencer #(
    .MEM_TIMEOUT(15),
    .CNT_W      (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .imem_ready    (imem_ready),
    .dmem_ready    (dmem_ready),
    .dec_reg_write (dec_reg_write),
    .dec_data_read (dec_data_read),
    .dec_data_write(dec_data_write),
    .dec_pc_sel    (dec_pc_sel),
    .dec_branch    (dec_branch),
    .br_taken      (br_taken),
    .imem_req      (imem_req),
    .ir_load       (ir_load),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .rf_we         (rf_we),
    .pc_we         (pc_we),
    .pc_src        (pc_src),
    .state         (state),
    .busy          (busy),
    .err           (err),
    .instr_count   (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] src;
    logic       rf;
    int         cyc;
    int         dreq;
    logic       dwe;
    logic [3:0] cnt;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_ret = 0;
  logic [3:0] model_cnt = 4'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Retire monitor: counts busy / dmem_req cycles since the last retire.
  initial begin
    int   cyc;
    int   dreq;
    logic dwe;
    exp_t e;
    cyc = 0; dreq = 0; dwe = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc = 0; dreq = 0; dwe = 1'b0;
      end else begin
        if (busy) cyc++;
        if (dmem_req) dreq++;
        if (dmem_req && dmem_we) dwe = 1'b1;
        if (pc_we) begin
          if (sb.size() == 0) begin
            check("unexpected_retire", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("pc_src", pc_src, e.src);
            check("rf_we", rf_we, e.rf);
            check("latency", cyc, e.cyc);
            check("dmem_req_cycles", dreq, e.dreq);
            check("dmem_we", dwe, e.dwe);
            check("instr_count", instr_count, e.cnt);
          end
          n_ret++;
          cyc = 0; dreq = 0; dwe = 1'b0;
        end
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the retire edge.
  task automatic run_instr(input logic rw, input logic rd, input logic wr,
                           input logic [1:0] sel, input logic br, input logic tk,
                           input int iw, input int dw, input logic drop,
                           input logic [1:0] esrc, input logic erf, input int ecyc,
                           input int edreq, input logic edwe);
    exp_t e;
    int   fn, mn, start;
    bit   done;
    dec_reg_write = rw; dec_data_read = rd; dec_data_write = wr;
    dec_pc_sel = sel; dec_branch = br; br_taken = tk;
    e = '{src: esrc, rf: erf, cyc: ecyc, dreq: edreq, dwe: edwe, cnt: model_cnt};
    sb.push_back(e);
    model_cnt++;
    fn = 0; mn = 0; start = n_ret; done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      imem_ready = (state == 3'd1) && (fn == iw);
      if (state == 3'd1) fn++;
      dmem_ready = (state == 3'd4) && (mn == dw);
      if (state == 3'd4) begin
        mn++;
        if (drop) run = 1'b0;
      end
      @(posedge clk); #1;
      if (n_ret != start) done = 1;
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    if (!done) check("retire_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int  n;
    bit  hit;
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state, 3'd0);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_count", instr_count, 4'd0);
    check("rst_imem_req", imem_req, 1'b0);
    rst = 1'b0;
    run = 1'b1;

    //        rw rd wr sel br tk iw dw drop src rf cyc dreq dwe
    run_instr(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 4, 0, 0);  // ALU
    run_instr(1, 1, 0, 0, 0, 0, 0, 3, 0, 2'd0, 1, 8, 4, 0);  // load, 3 waits
    run_instr(0, 0, 0, 0, 1, 1, 0, 0, 0, 2'd3, 0, 3, 0, 0);  // taken branch
    run_instr(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'd0, 0, 3, 0, 0);  // not-taken
    run_instr(0, 0, 0, 2, 0, 0, 0, 0, 0, 2'd2, 0, 3, 0, 0);  // jr
    run_instr(1, 0, 0, 1, 0, 0, 0, 0, 0, 2'd1, 1, 4, 0, 0);  // jal
    run_instr(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 4, 1, 1);  // store wins over load
    run_instr(1, 0, 0, 0, 0, 0, 2, 0, 0, 2'd0, 1, 6, 0, 0);  // ALU, 2 fetch waits
    run_instr(0, 0, 1, 0, 0, 0, 0, 3, 1, 2'd0, 0, 7, 4, 1);  // store, run dropped
    check("idle_after_drop", state, 3'd0);
    check("count_after_9", instr_count, model_cnt);

    // Reset during a load's MEM wait abandons it.
    run = 1'b1;
    dec_reg_write = 1'b1; dec_data_read = 1'b1; dec_data_write = 1'b0;
    dec_pc_sel = 2'b00; dec_branch = 1'b0;
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      imem_ready = (state == 3'd1);
      if (state == 3'd4) hit = 1;
      else begin @(posedge clk); #1; end
    end
    imem_ready = 1'b0;
    if (!hit) check("reach_mem_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    check("mem_still_waiting", dmem_req, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmem_state", state, 3'd0);
    check("rstmem_dmem_req", dmem_req, 1'b0);
    check("rstmem_pc_we", pc_we, 1'b0);
    check("rstmem_count", instr_count, 4'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_cnt = 4'd0;

    // Fetch timeout into ERR.
    n = 0; hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      if (imem_req) n++;
      if (state == 3'd6) hit = 1;
    end
    check("err_reached", hit, 1'b1);
    check("timeout_req_cycles", n, 15);
    check("err_flag", err, 1'b1);
    check("err_imem_req", imem_req, 1'b0);
    check("err_busy", busy, 1'b0);
    imem_ready = 1'b1; dmem_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("err_sticky", state, 3'd6);
    check("err_no_retire", pc_we, 1'b0);
    imem_ready = 1'b0; dmem_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("err_rst_state", state, 3'd0);
    check("err_rst_flag", err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 16 back-to-back jumps wrap the 4-bit counter.
    for (int i = 0; i < 16; i++)
      run_instr(0, 0, 0, 1, 0, 0, 0, 0, 0, 2'd1, 0, 3, 0, 0);
    check("count_wrap", instr_count, 4'd0);
    check("scoreboard_empty", sb.size(), 0);
    run = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
